// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : calc_pkg
// Brief   : Register map, opcodes, FSM states and AXI response codes
// Revision: 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam logic [7:0] REG_A    = 8'h00;
    localparam logic [7:0] REG_B    = 8'h04;
    localparam logic [7:0] REG_OP   = 8'h08;
    localparam logic [7:0] REG_RES  = 8'h0C;
    localparam logic [7:0] REG_MSEL = 8'h10;

    typedef enum logic [3:0] {
        ADD     = 4'd0,
        AND     = 4'd1,
        LOAD_A  = 4'd3,
        M_PLUS  = 4'd4,
        M_MINUS = 4'd5,
        MR      = 4'd6,
        MC      = 4'd7
    } calc_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } calc_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Write index 0/1/2 maps onto operand A, operand B, opcode.
    function automatic logic [7:0] wr_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    return REG_A;
            2'd1:    return REG_B;
            default: return REG_OP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_calc_master_if.sv
`default_nettype none
// ============================================================================
// Module  : axi4lite_calc_master_if
// Brief   : AXI4-Lite bus bundle with master/slave views
// Revision: 1.0 - initial release
// ============================================================================
interface axi4lite_calc_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              AW_VALID;
    logic              AW_READY;
    logic [ADDR_W-1:0] AW_ADDR;
    logic              W_VALID;
    logic              W_READY;
    logic [DATA_W-1:0] W_DATA;
    logic              B_VALID;
    logic              B_READY;
    logic [1:0]        B_RESP;
    logic              AR_VALID;
    logic              AR_READY;
    logic [ADDR_W-1:0] AR_ADDR;
    logic              R_VALID;
    logic              R_READY;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;

    modport master (
        output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
        input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );

    modport slave (
        input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
        output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );
endinterface
`default_nettype wire

// File: rtl/calc_wr_chan.sv
`default_nettype none
// ============================================================================
// Module  : calc_wr_chan
// Brief   : Tracks the independent AW and W handshakes of one write beat
// Revision: 1.0 - initial release
// ============================================================================
module calc_wr_chan (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic aw_ready_i,
    input  logic w_ready_i,
    output logic aw_valid_o,
    output logic w_valid_o,
    output logic hs_o,
    output logic done_o
);

    logic aw_done_q, aw_done_d;
    logic w_done_q,  w_done_d;
    logic aw_hs, w_hs;

    assign aw_valid_o = active_i & ~aw_done_q;
    assign w_valid_o  = active_i & ~w_done_q;
    assign aw_hs      = aw_valid_o & aw_ready_i;
    assign w_hs       = w_valid_o & w_ready_i;

    // Flags self-clear whenever the owner leaves the request phase.
    assign aw_done_d  = active_i & (aw_done_q | aw_hs);
    assign w_done_d   = active_i & (w_done_q | w_hs);
    assign hs_o       = aw_hs | w_hs;
    assign done_o     = aw_done_d & w_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4lite_calc_master.sv
`default_nettype none
// ============================================================================
// Module  : axi4lite_calc_master
// Brief   : Writes A/B/op to an AXI4-Lite calculator, reads back the result
// Revision: 1.0 - initial release
// ============================================================================
module axi4lite_calc_master
    import calc_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 256
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [3:0]        cmd_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    axi4lite_calc_master_if.master axi
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    calc_state_e       state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] a_q, b_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] wdata;
    logic              accept, wr_hs, wr_done, timeout, expire;

    assign accept  = (state_q == IDLE) && cmd_valid;
    assign timeout = (cnt_q >= CNT_LAST);

    calc_wr_chan u_wr_chan (
        .clk        (aclk),
        .rst        (areset),
        .active_i   (state_q == WR_REQ),
        .aw_ready_i (axi.AW_READY),
        .w_ready_i  (axi.W_READY),
        .aw_valid_o (axi.AW_VALID),
        .w_valid_o  (axi.W_VALID),
        .hs_o       (wr_hs),
        .done_o     (wr_done)
    );

    always_comb begin
        case (idx_q)
            2'd0:    wdata = a_q;
            2'd1:    wdata = b_q;
            default: wdata = DATA_W'(op_q);
        endcase
    end

    assign axi.AW_ADDR  = BASE_ADDR + ADDR_W'(wr_offset(idx_q));
    assign axi.W_DATA   = wdata;
    assign axi.B_READY  = (state_q == WR_RESP);
    assign axi.AR_VALID = (state_q == RD_REQ);
    assign axi.AR_ADDR  = BASE_ADDR + ADDR_W'(REG_RES);
    assign axi.R_READY  = (state_q == RD_RESP);
    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == DONE);
    assign rsp_data     = data_q;
    assign rsp_err      = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        data_d  = data_q;
        cnt_d   = cnt_q + CNT_W'(1);
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    state_d = WR_REQ;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            WR_REQ: begin
                if (wr_done) begin
                    state_d = WR_RESP;
                    cnt_d   = '0;
                end else if (wr_hs) begin
                    cnt_d   = '0;
                end else begin
                    expire  = timeout;
                end
            end
            WR_RESP: begin
                if (axi.B_VALID) begin
                    cnt_d = '0;
                    if (axi.B_RESP != OKAY) err_d = 1'b1;
                    if (idx_q == 2'd2) begin
                        state_d = RD_REQ;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = WR_REQ;
                    end
                end else begin
                    expire = timeout;
                end
            end
            RD_REQ: begin
                if (axi.AR_READY) begin
                    state_d = RD_RESP;
                    cnt_d   = '0;
                end else begin
                    expire  = timeout;
                end
            end
            RD_RESP: begin
                if (axi.R_VALID) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    data_d  = axi.R_DATA;
                    if (axi.R_RESP != OKAY) err_d = 1'b1;
                end else begin
                    expire  = timeout;
                end
            end
            DONE: begin
                cnt_d = '0;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A stalled slave ends the command with an error and a zero result.
        if (expire) begin
            state_d = DONE;
            err_d   = 1'b1;
            data_d  = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
            if (accept) begin
                a_q  <= cmd_a;
                b_q  <= cmd_b;
                op_q <= cmd_op;
            end
        end
    end

endmodule
`default_nettype wire
